// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access size, FSM state,
// byte-enable generation and misalignment detection.
package lsu_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StDone = 2'b10
  } lsu_state_e;

  // The reserved size encoding behaves as a word access.
  function automatic size_e decode_size(logic [1:0] sz);
    case (sz)
      2'b00:   return SizeByte;
      2'b01:   return SizeHalf;
      default: return SizeWord;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(size_e size, logic [1:0] off);
    case (size)
      SizeByte: return 4'b0001 << off;
      SizeHalf: return off[1] ? 4'b1100 : 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(size_e size, logic [1:0] off);
    case (size)
      SizeByte: return 1'b0;
      SizeHalf: return off[0];
      default:  return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: lane select, sign/zero extension and the ARM
// rotate applied to misaligned word loads.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        uns,
  input  logic        arm,
  output logic [31:0] data
);

  logic [4:0]  sh;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] rot;

  assign sh        = {off, 3'b000};
  assign byte_lane = 8'(rdata >> sh);
  assign half_lane = 16'(rdata >> {off[1], 4'b0000});
  // A shift of 32 yields zero, so off == 0 degenerates to a pass-through.
  assign rot       = (rdata >> sh) | (rdata << (6'd32 - {1'b0, sh}));

  always_comb begin
    data = rdata;
    case (size)
      SizeByte: data = {{24{byte_lane[7] & ~uns}}, byte_lane};
      SizeHalf: data = {{16{half_lane[15] & ~uns}}, half_lane};
      default:  data = arm ? rot : rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Memory-stage load/store unit: drives a request/ready data bus, stalls the
// pipeline for the duration of an access and returns extended load data.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              armM,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [1:0]        SizeM,
  input  logic              UnsignedM,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [31:0]       WriteDataM,
  output logic              StallM,
  output logic              MisalignM,
  output logic [31:0]       ReadDataW,
  output logic              dReq,
  output logic              dWE,
  output logic [ADDR_W-1:0] dAddr,
  output logic [3:0]        dBE,
  output logic [31:0]       dWData,
  input  logic              dReady,
  input  logic [31:0]       dRData
);

  lsu_state_e        state_q, state_d;
  logic              dreq_q, dreq_d;
  logic              dwe_q, dwe_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [3:0]        dbe_q, dbe_d;
  logic [31:0]       dwdata_q, dwdata_d;
  logic [31:0]       rdw_q, rdw_d;
  logic [1:0]        off_q, off_d;
  size_e             size_q, size_d;
  logic              uns_q, uns_d;
  logic              arm_q, arm_d;

  size_e       size_in;
  logic        acc;
  logic        fault;
  logic        stall;
  logic [31:0] wdata_rep;
  logic [31:0] load_data;

  assign size_in = decode_size(SizeM);
  assign acc     = MemReadM | MemWriteM;
  assign fault   = acc & ~armM & misaligned(size_in, ALUResultM[1:0]);

  always_comb begin
    case (size_in)
      SizeByte: wdata_rep = {4{WriteDataM[7:0]}};
      SizeHalf: wdata_rep = {2{WriteDataM[15:0]}};
      default:  wdata_rep = WriteDataM;
    endcase
  end

  // Extraction uses the offset/size captured at issue, not the live M inputs.
  load_align u_load_align (
    .rdata (dRData),
    .off   (off_q),
    .size  (size_q),
    .uns   (uns_q),
    .arm   (arm_q),
    .data  (load_data)
  );

  always_comb begin
    state_d  = state_q;
    dreq_d   = dreq_q;
    dwe_d    = dwe_q;
    daddr_d  = daddr_q;
    dbe_d    = dbe_q;
    dwdata_d = dwdata_q;
    rdw_d    = rdw_q;
    off_d    = off_q;
    size_d   = size_q;
    uns_d    = uns_q;
    arm_d    = arm_q;
    stall    = 1'b0;
    case (state_q)
      StIdle: begin
        if (acc && !fault) begin
          stall    = 1'b1;
          state_d  = StReq;
          dreq_d   = 1'b1;
          dwe_d    = MemWriteM;
          daddr_d  = {ALUResultM[ADDR_W-1:2], 2'b00};
          dbe_d    = byte_en(size_in, ALUResultM[1:0]);
          dwdata_d = wdata_rep;
          off_d    = ALUResultM[1:0];
          size_d   = size_in;
          uns_d    = UnsignedM;
          arm_d    = armM;
        end
      end
      StReq: begin
        stall = 1'b1;
        if (dReady) begin
          state_d = StDone;
          dreq_d  = 1'b0;
          if (!dwe_q) rdw_d = load_data;
        end
      end
      // The instruction leaves M here; never look at acc again for it.
      StDone: state_d = StIdle;
      default: begin
        state_d = StIdle;
        dreq_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      dreq_q   <= 1'b0;
      dwe_q    <= 1'b0;
      daddr_q  <= '0;
      dbe_q    <= '0;
      dwdata_q <= '0;
      rdw_q    <= '0;
      off_q    <= '0;
      size_q   <= SizeByte;
      uns_q    <= 1'b0;
      arm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dreq_q   <= dreq_d;
      dwe_q    <= dwe_d;
      daddr_q  <= daddr_d;
      dbe_q    <= dbe_d;
      dwdata_q <= dwdata_d;
      rdw_q    <= rdw_d;
      off_q    <= off_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      arm_q    <= arm_d;
    end
  end

  assign StallM    = reset_n & stall;
  assign MisalignM = reset_n & fault;
  assign ReadDataW = rdw_q;
  assign dReq      = dreq_q;
  assign dWE       = dwe_q;
  assign dAddr     = daddr_q;
  assign dBE       = dbe_q;
  assign dWData    = dwdata_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the memory stage of the combined ARM/RISC-V pipeline. It consumes the execute-stage result (`ALUResultM`, used as the address) and store data, and drives a single-master request/ready data-memory bus. It stalls the pipeline while an access is outstanding and delivers aligned, sign- or zero-extended load data to writeback. ARM and RISC-V differ only in how misaligned accesses are handled.

## Interface
Parameters:
- `ADDR_W`, 32, address width (bus and `ALUResultM`)

Ports:
- `clk`  in  1  core clock; all state on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `armM`  in  1  1 = ARM instruction, 0 = RISC-V
- `MemReadM`  in  1  load in M stage
- `MemWriteM`  in  1  store in M stage (never both with `MemReadM`)
- `SizeM`  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- `UnsignedM`  in  1  zero-extend loads when 1
- `ALUResultM`  in  32  byte address
- `WriteDataM`  in  32  store data, right-justified
- `StallM`  out  1  hold F/D/E/M pipeline registers
- `MisalignM`  out  1  RISC-V misaligned-access fault for the current M instruction
- `ReadDataW`  out  32  extended load result
- `dReq`  out  1  bus request
- `dWE`  out  1  write when 1
- `dAddr`  out  32  word-aligned address (`[1:0]` = 0)
- `dBE`  out  4  byte enables
- `dWData`  out  32  lane-replicated store data
- `dReady`  in  1  slave completes the access in this cycle
- `dRData`  in  32  read data, valid when `dReady`

## Operation
- `acc = MemReadM | MemWriteM`.
- Misaligned: half with `addr[0]`=1; word with `addr[1:0]`≠0.
- RISC-V misaligned: no bus access; `MisalignM`=1 combinationally; `StallM`=0; state stays IDLE; `ReadDataW` unchanged.
- ARM misaligned word: access at `addr & ~3`. Loads rotate the loaded word right by `8*addr[1:0]`. Stores ignore `addr[1:0]`. ARM misaligned half: `addr[0]` is ignored.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`; data `{4{wd[7:0]}}`
  - half: `0011` or `1100` by `addr[1]`; data `{2{wd[15:0]}}`
  - word: `1111`; data `wd`
- Load extract: shift `dRData` right by `8*addr[1:0]` (half uses `addr[1]` only). Take 8 or 16 bits, then sign-extend unless `UnsignedM`. Words pass through, with the ARM rotation above.
- FSM (states IDLE, REQ, DONE):
  - IDLE: on an aligned (or ARM) `acc`, go to REQ and register `dAddr`/`dBE`/`dWData`/`dWE`. `StallM`=1.
  - REQ: `dReq`=1, `StallM`=1. On `dReady`, go to DONE; for a load, latch the extracted data into `ReadDataW`.
  - DONE: `dReq`=0, `StallM`=0 so the instruction leaves M at this edge. Then go to IDLE unconditionally, so the same instruction is never re-issued.
- Reset (`reset_n`=0 at an edge): state IDLE; `dReq`, `dWE`, `dBE`, `ReadDataW`=0; `dAddr`, `dWData`=0. `StallM` and `MisalignM` are forced to 0 while `reset_n`=0.
- Reset mid-REQ abandons the access: `dReq` drops after that edge. A `dReady` seen during reset is ignored.

## Timing
- Minimum M residency for an access is 3 cycles: IDLE (stall), REQ (ready), DONE.
- Each wait cycle in REQ adds 1 cycle.
- Non-access instructions spend 1 cycle in M with `StallM`=0.
- While `dReq` & !`dReady`, `dAddr`/`dBE`/`dWData`/`dWE` are stable.
- `dReq` is registered (no combinational input→`dReq` path).
- `ReadDataW` is valid from the cycle after `dReady` (the DONE cycle) and holds until the next load completes.
- `dReady` is sampled only in REQ; it is ignored in IDLE and DONE.

## Structure
- `lsu_pkg`: `size_e` (BYTE/HALF/WORD), `lsu_state_e` (IDLE/REQ/DONE), a byte-enable function, and a misalign-check function.
- Sub-module `load_align`: combinational lane select, sign/zero extension and ARM rotate. Inputs: `dRData`, `addr[1:0]`, size, unsigned, arm.

## Test plan
- RISC-V LB, addr 0x1003, `dRData`=0x80AA_BBCC, `dReady` in the first REQ cycle → `dAddr`=0x1000; `ReadDataW`=0xFFFF_FF80; `StallM` high 2 cycles.
- RISC-V SH 0xBEEF @0x2002, slave waits 3 cycles → `dBE`=1100, `dWData`=0xBEEF_BEEF; signals stable through the waits; `StallM` high 5 cycles.
- RISC-V LW @0x3001 → `MisalignM`=1, `dReq` never asserts, `StallM`=0.
- ARM LDR @0x4001, `dRData`=0x4433_2211 → `dAddr`=0x4000, `ReadDataW`=0x1144_3322.
- `reset_n` low during REQ → next cycle `dReq`=0, state IDLE; a later `dReady` has no effect on `ReadDataW`.
- Back-to-back LBU @0x5000 then SW @0x5004 → two distinct bus transactions, each issued exactly once; `ReadDataW` = zero-extended byte 0.
